// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX operand info, dmem handshake, stage enables/flushes
// and the optional performance counters (populated when HAZARD_PERF_CNT_EN is defined).
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_regWEn;
  logic             ex_br_taken;
  logic             mem_access;
  logic             dmem_ready;
  logic             dmem_req;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, ex_regWEn,
           ex_br_taken, mem_access, dmem_ready,
    output dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_flush, mem_err, stall_cycles, flush_count
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, ex_regWEn,
           ex_br_taken, mem_access, dmem_ready,
    input  dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
           mem_wb_flush, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline with dmem handshake FSM and watchdog.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.master  bus
);

  localparam int unsigned TO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT - 1);

  typedef enum logic {M_IDLE, M_WAIT} state_t;

  state_t          state, state_next;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            mem_stall;
  logic            load_use;
  logic            mem_err_q;

  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, dmem_req;

  assign to_hit = (state == M_WAIT) && !bus.dmem_ready && (to_cnt == TO_MAX);

  assign mem_stall = ((state == M_IDLE) && bus.mem_access && !bus.dmem_ready) ||
                     ((state == M_WAIT) && !bus.dmem_ready && !to_hit);

  assign load_use = bus.ex_is_load && bus.ex_regWEn && (bus.ex_rd != 5'd0) &&
                    ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= M_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      M_IDLE: if (bus.mem_access && !bus.dmem_ready) state_next = M_WAIT;
      M_WAIT: if (bus.dmem_ready || to_hit)          state_next = M_IDLE;
      default:                                       state_next = M_IDLE;
    endcase
  end

  // Watchdog: counts cycles spent in M_WAIT, cleared on any exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (state == M_WAIT && state_next == M_WAIT) to_cnt <= to_cnt + TO_W'(1);
      else                                         to_cnt <= '0;
      if (to_hit) mem_err_q <= 1'b1;
    end
  end

  // Reset gating keeps every strobe low for the whole reset window, not just after an edge.
  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_flush = 1'b0;
    dmem_req     = 1'b0;
    if (!reset) begin
      dmem_req = (state == M_WAIT) ? 1'b1 : bus.mem_access;
      if (mem_stall) begin
        mem_wb_flush = 1'b1;
      end else if (bus.ex_br_taken) begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
      end else if (load_use) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
      end
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.dmem_req     = dmem_req;
  assign bus.mem_err      = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && stall_q != '1)       stall_q <= stall_q + CNT_W'(1);
      if (if_id_flush && flush_q != '1)  flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); control outputs compared as one packed vector.
module tb_pipe_hazard_ctrl;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush, dmem_req}
  localparam logic [7:0] V_OFF     = 8'b0000_0000;
  localparam logic [7:0] V_NORMAL  = 8'b1101_0100;
  localparam logic [7:0] V_ADV_REQ = 8'b1101_0101;
  localparam logic [7:0] V_MSTALL  = 8'b0000_0011;
  localparam logic [7:0] V_BRANCH  = 8'b1111_1100;
  localparam logic [7:0] V_BR_REQ  = 8'b1111_1101;
  localparam logic [7:0] V_LDUSE   = 8'b0001_1100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ctl_vec();
    return {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
            bus.ex_mem_en, bus.mem_wb_flush, bus.dmem_req};
  endfunction

  task automatic check_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_stall"}, 64'(bus.stall_cycles), 64'(exp_stall));
    check({tag, "_flush"}, 64'(bus.flush_count),  64'(exp_flush));
`else
    check({tag, "_stall"}, 64'(bus.stall_cycles), 64'd0);
    check({tag, "_flush"}, 64'(bus.flush_count),  64'd0);
`endif
  endtask

  // Inputs already applied; check mid-cycle, then cross one edge and track expected counters.
  task automatic step(input string tag, input logic [7:0] exp);
    #1;
    check(tag, 64'(ctl_vec()), 64'(exp));
    @(posedge clk);
    if (!exp[7]) exp_stall++;
    if (exp == V_BRANCH || exp == V_BR_REQ) exp_flush++;
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_is_load = 1'b0; bus.ex_regWEn = 1'b0; bus.ex_br_taken = 1'b0;
    bus.mem_access = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle_inputs();
    bus.mem_access  = 1'b1;
    bus.ex_br_taken = 1'b1;
    #2;
    check("rst_ctl", 64'(ctl_vec()), 64'(V_OFF));
    check("rst_err", 64'(bus.mem_err), 64'd0);
    check_cnt("rst");
    #20;
    idle_inputs();
    reset = 1'b0;

    step("idle", V_NORMAL);

    // Load-use on rs1, then the load moves to MEM and the hazard clears.
    bus.ex_is_load = 1'b1; bus.ex_regWEn = 1'b1; bus.ex_rd = 5'd5;
    bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
    step("lu_rs1", V_LDUSE);
    bus.ex_is_load = 1'b0;
    step("lu_done", V_NORMAL);
    check_cnt("lu");

    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    step("lu_x0", V_NORMAL);
    bus.ex_rd = 5'd7; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b1;
    step("lu_rs2", V_LDUSE);
    bus.id_uses_rs2 = 1'b0;
    step("lu_nouse", V_NORMAL);
    bus.id_uses_rs2 = 1'b1; bus.ex_regWEn = 1'b0;
    step("lu_nowe", V_NORMAL);

    // Taken branch wins over a live load-use.
    bus.ex_regWEn = 1'b1;
    bus.ex_br_taken = 1'b1;
    step("br_lu", V_BRANCH);
    check_cnt("br");

    // Memory wait with a pending branch: three stall cycles, then branch fires with the access.
    idle_inputs();
    bus.mem_access = 1'b1; bus.ex_br_taken = 1'b1;
    step("mw1", V_MSTALL);
    step("mw2", V_MSTALL);
    step("mw3", V_MSTALL);
    bus.dmem_ready = 1'b1;
    step("mw_done", V_BR_REQ);
    idle_inputs();
    step("mw_idle", V_NORMAL);
    check_cnt("mw");
    check("mw_err", 64'(bus.mem_err), 64'd0);

    // Zero-wait access.
    bus.mem_access = 1'b1; bus.dmem_ready = 1'b1;
    step("zw", V_ADV_REQ);
    idle_inputs();
    step("zw_idle", V_NORMAL);

    // Timeout: four stall cycles, then forced advance and sticky mem_err.
    bus.mem_access = 1'b1;
    step("to1", V_MSTALL);
    step("to2", V_MSTALL);
    step("to3", V_MSTALL);
    step("to4", V_MSTALL);
    check("to_err_pre", 64'(bus.mem_err), 64'd0);
    step("to_adv", V_ADV_REQ);
    bus.mem_access = 1'b0;
    check("to_err", 64'(bus.mem_err), 64'd1);
    step("to_idle", V_NORMAL);
    step("to_idle2", V_NORMAL);
    check("to_err_sticky", 64'(bus.mem_err), 64'd1);
    check_cnt("to");

    // Reset mid-wait: outputs drop without a clock edge.
    bus.mem_access = 1'b1;
    step("rw_enter", V_MSTALL);
    bus.mem_access = 1'b0;
    step("rw_wait", V_MSTALL);
    #1;
    reset = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    #1;
    check("rw_rst_ctl", 64'(ctl_vec()), 64'(V_OFF));
    check("rw_rst_err", 64'(bus.mem_err), 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    step("rw_idle", V_NORMAL);
    check_cnt("rw");
    check("rw_err", 64'(bus.mem_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
